// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared constants and types for the FIFO read-side stream adapter.
//   RD_LATENCY : cycles from fifo_rd_en to valid fifo_dout
//   SKID_DEPTH : entries in the read-side skid buffer
//   OCC_WIDTH  : width of occupancy and buffer indices
//   occ_t      : occupancy / index type
//   idx_next() : circular index increment, wraps SKID_DEPTH-1 -> 0
package fifo_pkg;

    localparam int RD_LATENCY = 1;
    localparam int SKID_DEPTH = 3;
    localparam int OCC_WIDTH  = 2;

    typedef logic [OCC_WIDTH-1:0] occ_t;

    function automatic occ_t idx_next(input occ_t idx);
        return (idx == occ_t'(SKID_DEPTH - 1)) ? '0 : idx + occ_t'(1);
    endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// rd_skid_buf
// Three-entry circular buffer that absorbs the FIFO read latency.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data at tail (caller never pushes when full)
//   push_data  : data to store
//   pop        : retire the head entry (caller never pops when empty)
//   occ        : number of stored entries, 0..3
//   head_data  : registered entry at head (zero after reset)
module rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output occ_t                  occ,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
    occ_t head;
    occ_t tail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= idx_next(tail);
            end
            if (pop) begin
                head <= idx_next(head);
            end
            // Simultaneous push and pop leave occupancy unchanged.
            occ <= occ + occ_t'(push) - occ_t'(pop);
        end
    end

    // Head data comes straight from storage, so fifo_dout never reaches
    // the stream output in the cycle it arrives.
    assign head_data = mem[head];

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
// Read-side consumer of the async FIFO: issues reads, captures the data one
// cycle later into a skid buffer and presents it as a valid/ready stream at
// full throughput. fifo_rd_en never depends on m_ready.
// Optional feature macro: FIFO_RD_CNT_EN adds rd_count, a wrapping count of
// accepted words.
// Ports:
//   clk, rst    : read-domain clock, asynchronous active-high reset
//   fifo_empty  : FIFO empty flag
//   fifo_rd_en  : FIFO read request
//   fifo_dout   : FIFO data, valid one cycle after fifo_rd_en
//   m_valid, m_ready, m_data : output stream
//   rd_count    : accepted-word count (FIFO_RD_CNT_EN only)
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  rd_count
`endif
);

    if (RD_LATENCY != 1 || CNT_WIDTH < 1 || DATA_WIDTH < 1) begin : g_bad_param
        $error("fifo_rd_stream: unsupported parameter combination");
    end

    logic       pend;
    logic       pop;
    occ_t       occ;
    logic [2:0] inflight;

    // Words already buffered plus the one still in flight must fit the buffer.
    assign inflight   = {1'b0, occ} + {2'b00, pend};
    assign fifo_rd_en = !rst && !fifo_empty && (inflight < 3'(SKID_DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
        end else begin
            pend <= fifo_rd_en;
        end
    end

    assign m_valid = (occ != '0);
    assign pop     = m_valid && m_ready;

    rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (pend),
        .push_data (fifo_dout),
        .pop       (pop),
        .occ       (occ),
        .head_data (m_data)
    );

`ifdef FIFO_RD_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count <= '0;
        end else if (pop) begin
            rd_count <= rd_count + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_dout;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
`ifdef FIFO_RD_CNT_EN
    logic [CW-1:0] rd_count;
`endif

    fifo_rd_stream #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef FIFO_RD_CNT_EN
        ,
        .rd_count   (rd_count)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model FIFO contents (not yet read) and scoreboard (not yet accepted).
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];

    int   cyc        = 0;
    logic rd_seen    = 1'b0;
    int   rd_pulses  = 0;
    int   ready_mode = 1;      // 0 low, 1 high, 2 random
    logic toggle_en  = 1'b0;
    logic hold_empty = 1'b0;
    int   first_valid_cyc = -1;
    int   acc_n = 0, acc_first = 0, acc_last = 0;
    int   acc_total = 0;
    logic [DW-1:0] last_acc = '0;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Read sampling: FIFO sees fifo_rd_en on the rising edge.
    always @(posedge clk) begin
        rd_seen = fifo_rd_en;
        if (fifo_rd_en) rd_pulses++;
        if (!rst) chk("no_read_when_empty", {31'd0, fifo_rd_en && fifo_empty}, 32'd0);
    end

    // Monitor / scoreboard, sampled away from the rising edge.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", {31'd0, m_valid}, 32'd1);
                chk("hold_data", {24'd0, m_data}, {24'd0, prev_data});
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {24'd0, m_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("stream_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
                end
                acc_n++;
                if (acc_n == 1) acc_first = cyc;
                acc_last  = cyc;
                acc_total++;
                last_acc  = m_data;
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
        end
    end

    // One clock of FIFO model and stream-sink behaviour, applied on the falling edge.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        if (rd_seen) begin
            if (fifo_q.size() == 0) chk("fifo_underflow", 32'd1, 32'd0);
            else fifo_dout = fifo_q.pop_front();
            rd_seen = 1'b0;
        end
        if (toggle_en && (cyc % 2 == 0)) hold_empty = !hold_empty;
        fifo_empty = (fifo_q.size() == 0) || hold_empty;
        case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        cycle();
        cycle();
        #3;
        chk({name, "_drained"}, exp_q.size(), 32'd0);
        chk({name, "_idle_valid"}, {31'd0, m_valid}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        rd_seen    = 1'b0;
        hold_empty = 1'b0;
        acc_total  = 0;
        #1;
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("rst_data", {24'd0, m_data}, 32'd0);
`ifdef FIFO_RD_CNT_EN
        chk("rst_count", {28'd0, rd_count}, 32'd0);
`endif
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout actual=%0d expected=finish", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        int fall_cyc;
        void'($urandom(32'h0000_5EED));
        rst        = 1'b1;
        fifo_empty = 1'b1;
        fifo_dout  = '0;
        m_ready    = 1'b0;
        #2;
        do_reset();

        // Single word with first-word latency.
        ready_mode = 1;
        rd_pulses  = 0;
        first_valid_cyc = -1;
        push_word(8'hA5);
        cycle();
        fall_cyc = cyc;
        drain("single", 20);
        chk("single_rd_pulses", rd_pulses, 32'd1);
        chk("single_latency", first_valid_cyc - fall_cyc, 32'd2);
        chk("single_last", {24'd0, last_acc}, 32'h0000_00A5);

        // Streaming with no bubbles.
        acc_n = 0;
        for (int i = 0; i < 16; i++) push_word(DW'(i));
        drain("stream", 60);
        chk("stream_count", acc_n, 32'd16);
        chk("stream_gapless", acc_last - acc_first, 32'd15);

        // Backpressure: only three words may be outstanding.
        ready_mode = 0;
        rd_pulses  = 0;
        for (int i = 0; i < 8; i++) push_word(DW'(i));
        repeat (10) cycle();
        #3;
        chk("bp_rd_pulses", rd_pulses, 32'd3);
        chk("bp_valid", {31'd0, m_valid}, 32'd1);
        chk("bp_data", {24'd0, m_data}, 32'd0);
        ready_mode = 1;
        drain("bp", 60);

        // Empty toggling with random sink readiness.
        ready_mode = 2;
        toggle_en  = 1'b1;
        for (int i = 0; i < 24; i++) push_word(DW'($urandom));
        drain("toggle", 600);
        toggle_en  = 1'b0;
        hold_empty = 1'b0;
        ready_mode = 1;

        // Reset with occ = 2 and a read in flight.
        ready_mode = 0;
        rd_pulses  = 0;
        for (int i = 0; i < 6; i++) push_word(DW'(8'h80 + i));
        begin
            int n = 0;
            while (rd_pulses < 3 && n < 20) begin
                cycle();
                n++;
            end
        end
        chk("pre_reset_pulses", rd_pulses, 32'd3);
        do_reset();
        ready_mode = 1;
        push_word(8'h3C);
        drain("post_reset", 20);
        chk("post_reset_first", {24'd0, last_acc}, 32'h0000_003C);

`ifdef FIFO_RD_CNT_EN
        // Counter wrap with a 4-bit count.
        do_reset();
        ready_mode = 2;
        for (int i = 0; i < 20; i++) push_word(DW'($urandom));
        drain("count", 300);
        #1;
        chk("count_wrap", {28'd0, rd_count}, 32'(acc_total % (1 << CW)));
        chk("count_is4", {28'd0, rd_count}, 32'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
